// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: DIGIT bits of a and b are summed per clock, LSB digit first,
// through a registered carry. Operands are latched on an accepted start; done pulses on completion.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = ($clog2(STEPS + 1) < 1) ? 1 : $clog2(STEPS + 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("serial_adder_n: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   step_q, step_d;

    logic [DIGIT:0]     digit_sum;
    logic [WIDTH-1:0]   res_shift;
    logic               msb_cin;
    logic               last_step;

    // The carry into the digit MSB is recovered from the MSB sum bit and its two operand bits.
    assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign msb_cin   = digit_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    assign res_shift = (res_q >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign last_step = (step_q == CNT_W'(STEPS - 1));

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        step_d  = step_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    step_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_shift;
                carry_d = digit_sum[DIGIT];
                step_d  = step_q + CNT_W'(1);
                if (last_step) begin
                    sum_d   = res_shift;
                    cout_d  = digit_sum[DIGIT];
                    ovf_d   = msb_cin ^ digit_sum[DIGIT];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            step_q  <= step_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n in three shapes: 8/1 directed, 16/4 directed, 4/2 exhaustive.
// Expectations come from an integer reference model and queue until the matching done pulse.
module tb_serial_adder_n;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic       rst8, start8, sub8, cin8;
    logic [7:0] a8, b8, sum8;
    logic       busy8, done8, cout8, ovf8;

    logic        rst_o;
    logic        start16, sub16, cin16;
    logic [15:0] a16, b16, sum16;
    logic        busy16, done16, cout16, ovf16;

    logic       start4, sub4, cin4;
    logic [3:0] a4, b4, sum4;
    logic       busy4, done4, cout4, ovf4;

    exp_t q8[$], q16[$], q4[$];
    exp_t e8, e16, e4;
    int   done_cnt8 = 0;

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder_n #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst_o), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    serial_adder_n #(.WIDTH(4), .DIGIT(2)) u_dut4 (
        .clk(clk), .rst(rst_o), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic exp_t model(input int w, input int av, input int bv_in, input logic c, input logic s);
        int   mask, bv, full;
        exp_t r;
        mask  = (1 << w) - 1;
        bv    = s ? (~bv_in & mask) : (bv_in & mask);
        full  = (av & mask) + bv + (s ? 1 : int'(c));
        r.sum  = 16'(full & mask);
        r.cout = ((full >> w) & 1) != 0;
        r.ovf  = ((((av >> (w-1)) & 1) == ((bv >> (w-1)) & 1)) &&
                  (((full >> (w-1)) & 1) != ((av >> (w-1)) & 1)));
        r.cyc  = 0;
        return r;
    endfunction

    // Done is expected in the cycle after edge (accepting edge + STEPS).
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                          input bit push);
        exp_t e;
        a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
        if (push) begin
            e = model(8, int'(a), int'(b), c, s);
            e.cyc = cyc + 1 + 8;
            q8.push_back(e);
        end
    endtask

    task automatic scramble8();
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    endtask

    task automatic wait_done8(output int busy_n, output bit ok);
        busy_n = 0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (done8) ok = 1'b1;
            else busy_n += int'(busy8);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            done_cnt8++;
            if (q8.size() == 0) check("d8_extra_done", 32'(done8), 32'd0);
            else begin
                e8 = q8.pop_front();
                check("d8_sum", 32'(sum8), 32'(e8.sum));
                check("d8_cout", 32'(cout8), 32'(e8.cout));
                check("d8_ovf", 32'(ovf8), 32'(e8.ovf));
                check("d8_latency", 32'(cyc), 32'(e8.cyc));
            end
        end
        if (done16) begin
            if (q16.size() == 0) check("d16_extra_done", 32'(done16), 32'd0);
            else begin
                e16 = q16.pop_front();
                check("d16_sum", 32'(sum16), 32'(e16.sum));
                check("d16_cout", 32'(cout16), 32'(e16.cout));
                check("d16_ovf", 32'(ovf16), 32'(e16.ovf));
                check("d16_latency", 32'(cyc), 32'(e16.cyc));
            end
        end
        if (done4) begin
            if (q4.size() == 0) check("d4_extra_done", 32'(done4), 32'd0);
            else begin
                e4 = q4.pop_front();
                check("d4_sum", 32'(sum4), 32'(e4.sum));
                check("d4_cout", 32'(cout4), 32'(e4.cout));
                check("d4_ovf", 32'(ovf4), 32'(e4.ovf));
                check("d4_latency", 32'(cyc), 32'(e4.cyc));
            end
        end
    end

    vec_t plan[5] = '{
        '{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0},
        '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1},
        '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0},
        '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1}
    };

    initial begin
        int busy_n, n0, d1, d2;
        bit ok;
        exp_t e;

        rst8 = 1'b1; rst_o = 1'b1;
        start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
        start16 = 0; sub16 = 0; cin16 = 0; a16 = '0; b16 = '0;
        start4 = 0; sub4 = 0; cin4 = 0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1 rst8 = 1'b0; rst_o = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);

        // Directed 8-bit cases; inputs are scrambled while running.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            issue8(plan[i].a, plan[i].b, plan[i].cin, plan[i].sub, 1'b1);
            @(posedge clk); #1;
            start8 = 1'b0;
            scramble8();
            wait_done8(busy_n, ok);
            check("plan_done_seen", 32'(ok), 32'd1);
            check("plan_busy_cycles", 32'(busy_n), 32'd8);
            check("plan_busy_at_done", 32'(busy8), 32'd0);
            check("plan_sum", 32'(sum8), 32'(plan[i].sum));
            check("plan_cout", 32'(cout8), 32'(plan[i].cout));
            check("plan_ovf", 32'(ovf8), 32'(plan[i].ovf));
        end

        // Start pulsed 3 cycles into a run must be ignored.
        @(posedge clk); #1;
        issue8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        start8 = 1'b0;
        n0 = done_cnt8;
        repeat (2) @(posedge clk);
        #1 issue8(8'hAA, 8'hBB, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(busy_n, ok);
        check("ign_done_seen", 32'(ok), 32'd1);
        check("ign_sum", 32'(sum8), 32'h46);
        repeat (15) @(posedge clk);
        #1;
        check("ign_done_count", 32'(done_cnt8 - n0), 32'd1);
        check("ign_sum_held", 32'(sum8), 32'h46);

        // Start held during the done cycle is accepted at once.
        @(posedge clk); #1;
        issue8(8'h21, 8'h43, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(busy_n, ok);
        d1 = cyc;
        issue8(8'h05, 8'h09, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(busy_n, ok);
        d2 = cyc;
        check("b2b_done_seen", 32'(ok), 32'd1);
        check("b2b_gap", 32'(d2 - d1), 32'd9);
        check("b2b_sum", 32'(sum8), 32'hFC);
        check("b2b_cout", 32'(cout8), 32'd0);

        // Reset in the fourth busy cycle discards the operation.
        @(posedge clk); #1;
        issue8(8'h55, 8'h22, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        n0 = done_cnt8;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_done", 32'(done8), 32'd0);
        check("mid_rst_sum", 32'(sum8), 32'd0);
        check("mid_rst_cout", 32'(cout8), 32'd0);
        check("mid_rst_ovf", 32'(ovf8), 32'd0);
        repeat (15) @(posedge clk);
        #1;
        check("mid_rst_no_done", 32'(done_cnt8 - n0), 32'd0);

        // 16-bit, 4-bit digits: four steps.
        @(posedge clk); #1;
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
        e = model(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
        e.cyc = cyc + 1 + 4;
        q16.push_back(e);
        @(posedge clk); #1;
        start16 = 1'b0;
        a16 = 16'h1234;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = done16;
        end
        check("w16_done_seen", 32'(ok), 32'd1);
        check("w16_sum", 32'(sum16), 32'h0000);
        check("w16_cout", 32'(cout16), 32'd1);
        check("w16_ovf", 32'(ovf16), 32'd0);

        // Exhaustive 4-bit, 2-bit digits, issued back to back from each done cycle.
        @(negedge clk);
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int m = 0; m < 4; m++) begin
                    a4 = 4'(av); b4 = 4'(bv); cin4 = m[0]; sub4 = m[1]; start4 = 1'b1;
                    e = model(4, av, bv, m[0], m[1]);
                    e.cyc = cyc + 1 + 2;
                    q4.push_back(e);
                    @(posedge clk); #1;
                    start4 = 1'b0;
                    ok = 1'b0;
                    for (int i = 0; i < 10 && !ok; i++) begin
                        @(negedge clk);
                        ok = done4;
                    end
                    check("w4_done_seen", 32'(ok), 32'd1);
                end
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q16_drained", 32'(q16.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
